isa_multicycle: RTL and testbench
=================================

ISA_MULTICYCLE -- requirements
Module: isa_multicycle

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the datapath and register width in bits (legal: 8..64).
REQ-002 The block SHALL take parameter NREG, default 32, as the number of architectural registers (power of two, 2..32); RADDR_W = clog2(NREG).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
clk  in  1  sole clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction word, MIPS R/I format
instr_valid  in  1  instr presented
instr_ready  out  1  block can accept instr
result  out  DATA_W  value written back in the WB cycle
result_valid  out  1  one-cycle pulse in the WB cycle
illegal  out  1  one-cycle pulse when an unsupported instruction is retired without write.

Function
REQ-004 Instruction handshake SHALL occur on a rising edge with instr_valid=1 and instr_ready=1; instr SHALL be captured into an internal register on that edge.
REQ-005 instr_ready SHALL be 1 only in state IDLE.
REQ-006 FSM states SHALL be IDLE, DECODE, EXEC and WB, with transitions IDLE->DECODE on handshake, DECODE->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-007 DECODE SHALL register rs=instr[25:21] and rt=instr[20:16] operands, taking the low RADDR_W bits of each field.
REQ-008 EXEC SHALL register the ALU result.
REQ-009 WB SHALL write the result into the register file on the WB->IDLE edge and assert result_valid during WB.
REQ-010 Latency SHALL be 3 cycles from the handshake edge to result_valid, with a maximum throughput of one instruction per 4 cycles.
REQ-011 R-type (opcode 0x00) SHALL write rd=instr[15:11] with funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 1 or 0).
REQ-012 addi (opcode 0x08) SHALL write rt with rs + sign-extended instr[15:0].
REQ-013 The immediate SHALL be truncated or sign-extended to DATA_W.
REQ-014 Arithmetic SHALL wrap modulo 2^DATA_W; there SHALL be no overflow trap.
REQ-015 Register 0 SHALL read as 0 and writes to it SHALL be discarded; result_valid still pulses with the computed value.
REQ-016 Any other opcode or funct SHALL pulse illegal in WB instead of result_valid, suppress the write and drive result to 0.
REQ-017 instr_valid outside IDLE SHALL be ignored, and instr SHALL NOT be sampled.
REQ-018 A read in DECODE of a register written on the immediately preceding WB edge SHALL return the new value, since the write completes before the next instruction reaches DECODE.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state IDLE, all registers and internal pipeline registers to 0, result=0, result_valid=0 and illegal=0; instr_ready=1 SHALL hold while in reset.
REQ-020 Reset asserted mid-instruction SHALL abort it with no register write.
REQ-021 The first handshake SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-022 With macro ISA_SHIFT_EN defined, R-type funct 0x00 sll and 0x02 srl SHALL be supported, operating on rt by shamt=instr[10:6] (shamt >= DATA_W yields 0) and writing rd.
REQ-023 Without ISA_SHIFT_EN, funct 0x00 and 0x02 SHALL be illegal per REQ-016.

Structure
REQ-024 A shared package isa_pkg SHALL hold the opcode and funct constants, the FSM state enum and the ALU-op enum.
REQ-025 The register file SHALL be a sub-module isa_regfile (NREG x DATA_W, two asynchronous read ports, one synchronous write port, reg 0 hardwired zero); the ALU SHALL be inline.

Verification
REQ-026 After reset, addi r1,r0,5 -> result_valid exactly 3 cycles after the handshake with result=5, and instr_ready low for 3 cycles.
REQ-027 With r1=5 and r2=-3 (addi), add r3,r1,r2 -> result=2; sub r4,r2,r1 -> result=0xFFFFFFF8; slt r5,r2,r1 -> 1.
REQ-028 addi r0,r0,7 -> result=7, result_valid=1; a following add r6,r0,r0 -> result=0.
REQ-029 Opcode 0x23 and R-type funct 0x18 -> illegal pulse in WB, result_valid=0, and no register change (verified by reading back via add).
REQ-030 rst_n pulsed low during EXEC of addi r7,r0,9 -> no result_valid, and add r8,r7,r0 after reset gives 0.
REQ-031 With ISA_SHIFT_EN and r1=5, sll r2,r1,4 -> 0x50; without ISA_SHIFT_EN the same instr -> illegal; also run with DATA_W=16, NREG=8: addi r1,r0,0x7FFF then add r2,r1,r1 -> 0xFFFE.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared opcode/funct constants, FSM state and ALU-op enums, and the instruction decoder.
// Build macro ISA_SHIFT_EN adds the sll/srl R-type functs.
package isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_ILL
  } alu_op_e;

  // Map opcode/funct to an ALU operation; anything unsupported becomes ALU_ILL.
  function automatic alu_op_e decode_op(input logic [5:0] opcode, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ILL;
    if (opcode == OP_ADDI) begin
      op = ALU_ADD;
    end else if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  op = ALU_ADD;
        FN_SUB:  op = ALU_SUB;
        FN_AND:  op = ALU_AND;
        FN_OR:   op = ALU_OR;
        FN_NOR:  op = ALU_NOR;
        FN_SLT:  op = ALU_SLT;
`ifdef ISA_SHIFT_EN
        FN_SLL:  op = ALU_SLL;
        FN_SRL:  op = ALU_SRL;
`endif
        default: op = ALU_ILL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/isa_regfile.sv
// NREG x DATA_W register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module isa_regfile #(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned NREG    = 32,
  localparam int unsigned RADDR_W = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RADDR_W-1:0] raddr_a_i,
  input  logic [RADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]  rdata_a_o,
  output logic [DATA_W-1:0]  rdata_b_o,
  input  logic               we_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]  wdata_i
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/isa_multicycle.sv
// Four-state (IDLE/DECODE/EXEC/WB) multicycle core for a MIPS R/I subset with an inline ALU.
// Build macro ISA_SHIFT_EN enables sll/srl.
module isa_multicycle
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal
);

  localparam int unsigned RADDR_W = $clog2(NREG);

  state_e              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  alu_op_e             op_q, op_d;
  logic [RADDR_W-1:0]  waddr_q, waddr_d;
  logic [4:0]          shamt_q, shamt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                rv_q, rv_d, ill_q, ill_d, ready_q, ready_d;

  logic [DATA_W-1:0]   rs_val, rt_val, alu_c;
  logic [5:0]          opcode_c;

  assign opcode_c = instr_q[31:26];

  isa_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a_i (instr_q[21 +: RADDR_W]),
    .raddr_b_i (instr_q[16 +: RADDR_W]),
    .rdata_a_o (rs_val),
    .rdata_b_o (rt_val),
    .we_i      ((state_q == ST_WB) && rv_q),
    .waddr_i   (waddr_q),
    .wdata_i   (result_q)
  );

  // Inline ALU; all arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    alu_c = '0;
    case (op_q)
      ALU_ADD: alu_c = a_q + b_q;
      ALU_SUB: alu_c = a_q - b_q;
      ALU_AND: alu_c = a_q & b_q;
      ALU_OR:  alu_c = a_q | b_q;
      ALU_NOR: alu_c = ~(a_q | b_q);
      ALU_SLT: alu_c = DATA_W'($signed(a_q) < $signed(b_q));
      ALU_SLL: alu_c = (32'(shamt_q) >= DATA_W) ? '0 : (b_q << shamt_q);
      ALU_SRL: alu_c = (32'(shamt_q) >= DATA_W) ? '0 : (b_q >> shamt_q);
      default: alu_c = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    waddr_d  = waddr_q;
    shamt_d  = shamt_q;
    result_d = '0;
    rv_d     = 1'b0;
    ill_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = rs_val;
        op_d    = decode_op(opcode_c, instr_q[5:0]);
        shamt_d = instr_q[10:6];
        if (opcode_c == OP_ADDI) begin
          b_d     = DATA_W'($signed(instr_q[15:0]));
          waddr_d = instr_q[16 +: RADDR_W];
        end else begin
          b_d     = rt_val;
          waddr_d = instr_q[11 +: RADDR_W];
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_q == ALU_ILL) begin
          ill_d = 1'b1;
        end else begin
          rv_d     = 1'b1;
          result_d = alu_c;
        end
        state_d = ST_WB;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      waddr_q  <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      ill_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      waddr_q  <= waddr_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      ill_q    <= ill_d;
      ready_q  <= ready_d;
    end
  end

  assign instr_ready  = ready_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_isa_multicycle.sv
// Directed bench for isa_multicycle: default 32-bit/32-reg instance plus a 16-bit/8-reg instance.
module tb_isa_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        valid_a, valid_b;
  logic        ready_a, rv_a, ill_a, ready_b, rv_b, ill_b;
  logic [31:0] res_a;
  logic [15:0] res_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  isa_multicycle #(.DATA_W(32), .NREG(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(valid_a), .instr_ready(ready_a),
    .result(res_a), .result_valid(rv_a), .illegal(ill_a)
  );

  isa_multicycle #(.DATA_W(16), .NREG(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(valid_b), .instr_ready(ready_b),
    .result(res_b), .result_valid(rv_b), .illegal(ill_b)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one instruction at the current negedge and check the 3-cycle response.
  task automatic run(input bit sel, input logic [31:0] ins, input logic [31:0] exp_res,
                     input bit exp_ill, input string tag);
    logic        rdy, rv, ill;
    logic [31:0] res;
    instr = ins;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    #1;
    instr = 32'h2001_1234;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      rdy = sel ? ready_b : ready_a;
      rv  = sel ? rv_b : rv_a;
      ill = sel ? ill_b : ill_a;
      res = sel ? {16'h0, res_b} : res_a;
      chk({tag, "/ready_busy"}, 32'(rdy), 32'd0);
      if (c < 3) begin
        chk({tag, "/early_valid"}, 32'({rv, ill}), 32'd0);
      end else begin
        chk({tag, "/valid"}, 32'(rv), 32'(!exp_ill));
        chk({tag, "/illegal"}, 32'(ill), 32'(exp_ill));
        chk({tag, "/result"}, res, exp_res);
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    @(negedge clk);
    rdy = sel ? ready_b : ready_a;
    rv  = sel ? rv_b : rv_a;
    chk({tag, "/ready_back"}, 32'(rdy), 32'd1);
    chk({tag, "/valid_drop"}, 32'(rv), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    instr   = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/ready", 32'(ready_a), 32'd1);
    chk("rst/valid", 32'(rv_a), 32'd0);
    chk("rst/illegal", 32'(ill_a), 32'd0);
    chk("rst/result", res_a, 32'd0);
    chk("rst/ready_b", 32'(ready_b), 32'd1);
    rst_n = 1'b1;

    run(0, itype(6'h08, 5'd0, 5'd1, 16'd5), 32'd5, 0, "addi_r1");
    run(0, itype(6'h08, 5'd0, 5'd2, 16'hFFFD), 32'hFFFF_FFFD, 0, "addi_r2");
    run(0, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd2, 0, "add");
    run(0, rtype(5'd2, 5'd1, 5'd4, 5'd0, 6'h22), 32'hFFFF_FFF8, 0, "sub");
    run(0, rtype(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A), 32'd1, 0, "slt_true");
    run(0, rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h2A), 32'd0, 0, "slt_false");
    run(0, rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h24), 32'd5, 0, "and");
    run(0, rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h25), 32'hFFFF_FFFD, 0, "or");
    run(0, rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h27), 32'd2, 0, "nor");
    run(0, rtype(5'd9, 5'd3, 5'd10, 5'd0, 6'h20), 32'd4, 0, "fwd_r9");
    run(0, itype(6'h08, 5'd0, 5'd0, 16'd7), 32'd7, 0, "addi_r0");
    run(0, rtype(5'd0, 5'd0, 5'd6, 5'd0, 6'h20), 32'd0, 0, "r0_zero");

    run(0, itype(6'h23, 5'd0, 5'd1, 16'd0), 32'd0, 1, "ill_op23");
    run(0, rtype(5'd1, 5'd0, 5'd10, 5'd0, 6'h20), 32'd5, 0, "r1_kept_a");
    run(0, rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h18), 32'd0, 1, "ill_fn18");
    run(0, rtype(5'd1, 5'd0, 5'd10, 5'd0, 6'h20), 32'd5, 0, "r1_kept_b");

`ifdef ISA_SHIFT_EN
    run(0, rtype(5'd0, 5'd1, 5'd2, 5'd4, 6'h00), 32'h50, 0, "sll");
    run(0, rtype(5'd0, 5'd2, 5'd11, 5'd4, 6'h02), 32'h5, 0, "srl");
`else
    run(0, rtype(5'd0, 5'd1, 5'd2, 5'd4, 6'h00), 32'd0, 1, "sll_ill");
    run(0, rtype(5'd2, 5'd0, 5'd11, 5'd0, 6'h20), 32'hFFFF_FFFD, 0, "r2_kept");
`endif

    run(0, itype(6'h08, 5'd0, 5'd12, 16'hFFFF), 32'hFFFF_FFFF, 0, "addi_m1");
    run(0, rtype(5'd12, 5'd1, 5'd13, 5'd0, 6'h20), 32'd4, 0, "add_wrap");

    // Abort addi r7,r0,9 with reset asserted during EXEC.
    instr   = itype(6'h08, 5'd0, 5'd7, 16'd9);
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort/ready_in_reset", 32'(ready_a), 32'd1);
    @(negedge clk);
    chk("abort/no_valid", 32'(rv_a), 32'd0);
    @(negedge clk);
    chk("abort/no_valid_wb", 32'(rv_a), 32'd0);
    rst_n = 1'b1;
    run(0, rtype(5'd7, 5'd0, 5'd8, 5'd0, 6'h20), 32'd0, 0, "abort_r7");
    run(0, rtype(5'd1, 5'd0, 5'd10, 5'd0, 6'h20), 32'd0, 0, "rst_clears_r1");

    run(1, itype(6'h08, 5'd0, 5'd1, 16'h7FFF), 32'h7FFF, 0, "w16_addi");
    run(1, rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h20), 32'hFFFE, 0, "w16_add");
    run(1, itype(6'h08, 5'd0, 5'd3, 16'hFFFF), 32'hFFFF, 0, "w16_addi_m1");
    run(1, rtype(5'd3, 5'd1, 5'd4, 5'd0, 6'h2A), 32'd1, 0, "w16_slt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
